// File: rtl/dbus_mem_responder_pkg.sv
// Shared types for the data-bus memory responder.
//   msize_t            : access size encoding (byte/half/word/double)
//   dbus_req_t         : core-to-memory request payload
//   dbus_resp_t        : memory-to-core response payload
//   dbus_resp_state_t  : responder FSM states
//   DBUS_RESP_MAX_LAT  : largest supported response latency
package dbus_mem_responder_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dbus_resp_state_t;

  localparam int unsigned DBUS_RESP_MAX_LAT = 15;

endpackage

// File: rtl/dbus_resp_sram.sv
// Backing word array for the data-bus responder.
//   clk        : write clock
//   i_we       : write enable (bytes selected by i_strobe)
//   i_addr     : word index, shared by read and write
//   i_strobe   : per-byte write lanes
//   i_wdata    : write data
//   o_rdata_c  : combinational read of the addressed word
// Contents are deliberately not reset.
module dbus_resp_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_strobe,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata_c
);

  logic [63:0] r_mem [DEPTH_WORDS];

  // Byte-lane write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 8; i++) begin
        if (i_strobe[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/dbus_mem_responder.sv
// Memory-side responder for the core data bus: fixed-latency, byte-strobed
// 64-bit word memory with range (and optional alignment) rejection.
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   dreq   : request from the core MEM stage
//   dresp  : registered response (addr_ok/data_ok pulse together for one cycle)
//   err    : registered one-cycle pulse with data_ok when the access is rejected
// Build option: define DBUS_RESP_ALIGN_CHECK_EN to reject accesses whose
// address is misaligned for their size.
module dbus_mem_responder
  import dbus_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(DBUS_RESP_MAX_LAT + 1);

  dbus_resp_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_latch;

  logic [63:0] r_addr, r_wdata;
  msize_t      r_size;
  logic [7:0]  r_strobe;

  logic [63:0] w_cur_addr, w_cur_wdata, w_mem_rdata;
  msize_t      w_cur_size;
  logic [7:0]  w_cur_strobe;
  logic [60:0] w_word;
  logic        w_in_range, w_reject, w_enter_resp, w_we;

  logic        r_ok, r_err;
  logic [63:0] r_rdata;

  // State register and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; WAIT counts cnt down to zero, abort on valid drop.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (dreq.valid) begin
          w_latch = 1'b1;
          if (LATENCY <= 1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (!dreq.valid) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latched request; held for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_size   <= MSIZE1;
      r_strobe <= '0;
      r_wdata  <= '0;
    end else if (w_latch) begin
      r_addr   <= dreq.addr;
      r_size   <= dreq.size;
      r_strobe <= dreq.strobe;
      r_wdata  <= dreq.data;
    end
  end

  // With LATENCY == 1 the access resolves on the accept edge, so use dreq directly.
  assign w_cur_addr   = (r_state == IDLE) ? dreq.addr   : r_addr;
  assign w_cur_size   = (r_state == IDLE) ? dreq.size   : r_size;
  assign w_cur_strobe = (r_state == IDLE) ? dreq.strobe : r_strobe;
  assign w_cur_wdata  = (r_state == IDLE) ? dreq.data   : r_wdata;

  // Word offset from BASE_ADDR; the full-width compare catches indices past the array.
  assign w_word     = w_cur_addr[63:3] - BASE_ADDR[63:3];
  assign w_in_range = (w_cur_addr >= BASE_ADDR) && (w_word < 61'(DEPTH_WORDS));

`ifdef DBUS_RESP_ALIGN_CHECK_EN
  logic w_misaligned;

  always_comb begin
    w_misaligned = 1'b0;
    case (w_cur_size)
      MSIZE2:  w_misaligned = w_cur_addr[0];
      MSIZE4:  w_misaligned = |w_cur_addr[1:0];
      MSIZE8:  w_misaligned = |w_cur_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_reject = !w_in_range || w_misaligned;
`else
  assign w_reject = !w_in_range;
`endif

  // Read, write and response all resolve on the edge that enters RESP.
  assign w_enter_resp = (w_state_nxt == RESP);
  assign w_we         = w_enter_resp && !w_reject && (w_cur_strobe != 8'h00);

  dbus_resp_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk       (clk),
    .i_we      (w_we),
    .i_addr    (w_word[AW-1:0]),
    .i_strobe  (w_cur_strobe),
    .i_wdata   (w_cur_wdata),
    .o_rdata_c (w_mem_rdata)
  );

  // Response registers; high only during the RESP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ok    <= w_enter_resp;
      r_err   <= w_enter_resp && w_reject;
      r_rdata <= (w_enter_resp && !w_reject && (w_cur_strobe == 8'h00)) ? w_mem_rdata : '0;
    end
  end

  assign dresp.addr_ok = r_ok;
  assign dresp.data_ok = r_ok;
  assign dresp.data    = r_rdata;
  assign err           = r_err;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Directed scoreboard bench for dbus_mem_responder (default parameters).
module tb_dbus_mem_responder;
  import dbus_mem_responder_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       err;

  always #5 clk = ~clk;

  dbus_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq),
    .dresp (dresp),
    .err   (err)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] addr, input msize_t size,
                       input logic [7:0] strobe, input logic [63:0] data);
    dreq.valid  = 1'b1;
    dreq.addr   = addr;
    dreq.size   = size;
    dreq.strobe = strobe;
    dreq.data   = data;
  endtask

  // Wait (bounded) for data_ok, then compare against the scoreboard head.
  task automatic wait_resp(input string tag, input int exp_lat);
    int   cyc;
    exp_t e;
    cyc = 0;
    e.data = 64'hx;
    e.err  = 1'bx;
    if (sb.size() > 0) e = sb.pop_front();
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (dresp.data_ok) break;
    end
    check({tag, "_data_ok"}, 64'(dresp.data_ok), 64'd1);
    check({tag, "_lat"},     64'(cyc),           64'(exp_lat));
    check({tag, "_addr_ok"}, 64'(dresp.addr_ok), 64'd1);
    check({tag, "_data"},    dresp.data,         e.data);
    check({tag, "_err"},     64'(err),           64'(e.err));
  endtask

  // Full access: request, response, then confirm the pulse lasts one cycle.
  task automatic access(input string tag, input logic [63:0] addr, input msize_t size,
                        input logic [7:0] strobe, input logic [63:0] data,
                        input logic [63:0] exp_data, input logic exp_err);
    exp_t e;
    e.data = exp_data;
    e.err  = exp_err;
    drive(addr, size, strobe, data);
    sb.push_back(e);
    wait_resp(tag, LAT);
    dreq.valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(dresp.data_ok), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    exp_t e;

    reset = 1'b1;
    dreq  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_ok", 64'(dresp.addr_ok), 64'd0);
    check("rst_data_ok", 64'(dresp.data_ok), 64'd0);
    check("rst_err",     64'(err),           64'd0);
    check("rst_data",    dresp.data,         64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Full write then read of the same word.
    access("wr_full", 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
    access("rd_full", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 1'b0);

    // Partial strobe merge.
    access("wr_part", 64'h8000_0010, MSIZE8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 64'd0, 1'b0);
    access("rd_part", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BBBB_BBBB, 1'b0);

    // Reset during WAIT discards the pending write.
    drive(64'h8000_0010, MSIZE8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    check("rstw_data_ok", 64'(dresp.data_ok), 64'd0);
    check("rstw_data",    dresp.data,         64'd0);
    dreq.valid = 1'b0;
    #1 reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (dresp.data_ok) seen++;
    end
    check("rstw_no_resp", 64'(seen), 64'd0);
    access("rd_after_rst", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BBBB_BBBB, 1'b0);

    // Out of range below base and one word past the end.
    access("oor_low",  64'h7FFF_FFF8, MSIZE8, 8'h00, 64'd0, 64'd0, 1'b1);
    access("oor_high", BASE + 64'(8 * DEPTH), MSIZE8, 8'h00, 64'd0, 64'd0, 1'b1);
    access("oor_wr",   BASE + 64'(8 * DEPTH), MSIZE8, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, 64'd0, 1'b1);

    // Last in-range word.
    access("wr_last", 64'h8000_1FF8, MSIZE8, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 64'd0, 1'b0);
    access("rd_last", 64'h8000_1FF8, MSIZE8, 8'h00, 64'd0, 64'h0F0E_0D0C_0B0A_0908, 1'b0);

    // Abort: valid drops during WAIT.
    drive(64'h8000_0010, MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (dresp.data_ok) seen++;
    end
    check("abort_no_resp", 64'(seen), 64'd0);
    access("rd_after_abort", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BBBB_BBBB, 1'b0);

    // Back-to-back with valid held: second response LAT+1 cycles after the first.
    drive(64'h8000_0010, MSIZE8, 8'h00, 64'd0);
    e.data = 64'h1122_3344_BBBB_BBBB;
    e.err  = 1'b0;
    sb.push_back(e);
    wait_resp("b2b_a", LAT);
    drive(64'h8000_1FF8, MSIZE8, 8'h00, 64'd0);
    e.data = 64'h0F0E_0D0C_0B0A_0908;
    e.err  = 1'b0;
    sb.push_back(e);
    wait_resp("b2b_b", LAT + 1);
    dreq.valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_pulse", 64'(dresp.data_ok), 64'd0);

    // Misaligned word write at byte offset 2.
`ifdef DBUS_RESP_ALIGN_CHECK_EN
    access("mis_wr", 64'h8000_0012, MSIZE4, 8'h0C, 64'h0000_0000_CCDD_0000, 64'd0, 1'b1);
    access("mis_rd", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BBBB_BBBB, 1'b0);
`else
    access("mis_wr", 64'h8000_0012, MSIZE4, 8'h0C, 64'h0000_0000_CCDD_0000, 64'd0, 1'b0);
    access("mis_rd", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_CCDD_BBBB, 1'b0);
`endif

    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_mem_responder.md
# dbus_mem_responder

Memory-side responder for the core's data bus. It accepts `dbus_req_t` requests from the core's MEM stage and answers with `dbus_resp_t` after a fixed, parameterised latency. Behind the bus is a byte-strobed 64-bit word array. The block serves as the simulation and FPGA stand-in for the data memory, and exercises the core's `stallM` / `data_ok` stall path.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 64-bit words in the backing array; power of two.
- `LATENCY`, default 2: cycles from request acceptance to `data_ok`; legal range 1..15.
- `BASE_ADDR`, default 64'h8000_0000: byte address of word 0.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dreq`  in  `dbus_req_t`  request: `valid`, `addr`, `size`, `strobe`, `data`.
- `dresp`  out  `dbus_resp_t`  response: `addr_ok`, `data_ok`, `data`.
- `err`  out  1  one-cycle pulse alongside `data_ok` when the access was rejected.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE:** on `dreq.valid`, latch `addr`, `size`, `strobe` and `data`, load `cnt = LATENCY-1`, and go to WAIT. If `LATENCY == 1`, go straight to RESP.
- **WAIT:** decrement `cnt` each cycle; at `cnt == 0`, go to RESP.
  - If `dreq.valid` drops in WAIT, the access is aborted: return to IDLE, no write, no response.
- **RESP:** assert `addr_ok = data_ok = 1` for exactly one cycle, then return to IDLE.
  - Read (`strobe == 0`): `dresp.data` = the full addressed word. The core extracts bytes using `addr[2:0]`.
  - Write (`strobe != 0`): at the RESP clock edge, the bytes with `strobe[i] == 1` take `data[8i+7:8i]`. `dresp.data` = 0.
- Index = `(addr - BASE_ADDR) >> 3`, truncated to log2(`DEPTH_WORDS`) bits after a range check.
- Out of range (`addr < BASE_ADDR` or index ≥ `DEPTH_WORDS`): RESP still occurs; data = 0, no write, `err = 1`.
- The requester holds `dreq` stable from `valid` rising until `data_ok`. Requests arriving while in WAIT/RESP are not re-sampled.

## Timing
- Reset values: state = IDLE, `cnt` = 0, `addr_ok` = `data_ok` = `err` = 0, `dresp.data` = 0. The array contents are not reset.
- Reset asserted mid-operation returns to IDLE immediately (asynchronously). A pending write is discarded.
- Latency: `valid` sampled in cycle T produces `data_ok` in cycle T+`LATENCY`.
- Response outputs are registered; no combinational path from `dreq` to `dresp`.
- Back-to-back requests: the cycle after RESP is IDLE, and a `valid` request present then is accepted. Sustained throughput is one access per `LATENCY+1` cycles.
- A read that follows a write to the same word observes the written bytes.

## Configuration
- `DBUS_RESP_ALIGN_CHECK_EN` defined:
  - An access whose `addr` is not aligned to `size` (half on odd address, word on `addr[1:0] != 0`, double on `addr[2:0] != 0`) completes with `err = 1`, data = 0, and no write.
  - Rejection happens only in RESP, so latency is unchanged.
- `DBUS_RESP_ALIGN_CHECK_EN` undefined: `addr[2:0]` is ignored for indexing and misaligned accesses proceed using the strobes as given.

## Structure
- Shared package `common`: add enum `dbus_resp_state_t` (IDLE, WAIT, RESP) and localparam `DBUS_RESP_MAX_LAT = 15`. The `dbus_req_t` / `dbus_resp_t` types already live there.
- One sub-module, `dbus_resp_sram`: a `DEPTH_WORDS` × 64 array with a synchronous 8-lane byte-strobe write and a combinational read, instantiated once.
- The top level holds the FSM, the latency counter, the latched request, the range/alignment checks and the output registers.

## Test plan
- **Reset mid-WAIT:** issue a write, then pulse `reset` during WAIT. Expect outputs to read 0 and the word to be unchanged.
- **Write then read:** with `LATENCY = 2`, write to `addr` 8000_0010 with `strobe` = FF and `data` = 1122334455667788. Expect `data_ok` at T+2. Then read the same address and expect `data` = 1122334455667788 at T'+2.
- **Partial strobe:** write with `strobe` = 0F and `data` = AAAA_AAAA_BBBB_BBBB over the word above. A read must return 1122_3344_BBBB_BBBB.
- **Out of range:** read `addr` 7FFF_FFF8, and separately `BASE_ADDR` + 8×`DEPTH_WORDS`. Expect `data_ok` = 1, `err` = 1, `data` = 0.
- **Abort:** drop `valid` in WAIT on a write. Expect no `data_ok`, memory unchanged, and the next request accepted normally.
- **Misaligned word write** (`size` = word, `addr` 8000_0012): with `DBUS_RESP_ALIGN_CHECK_EN` defined, expect `err` = 1 and no write. Without it, expect the strobed bytes written.
